// File: rtl/vector_wb_queue.sv
`default_nettype none
// vector_wb_queue: in-order vector register-file write-back queue with read-hazard detection.
// Optional feature macro VWB_MERGE_EN: coalesce an offer into the youngest entry on address match.
// Revision: 1.0
module vector_wb_queue #(
   parameter int DEPTH = 4,
   parameter int LANES = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [4:0]              in_addr,
   input  logic [31:0]             in_data [LANES-1:0],
   input  logic [LANES-1:0]        in_mask,
   input  logic                    hold,
   output logic [4:0]              write_addr,
   output logic [31:0]             write_vector [LANES-1:0],
   output logic [LANES-1:0]        we,
   input  logic [4:0]              read1,
   input  logic [4:0]              read2,
   output logic                    rd_hazard1,
   output logic                    rd_hazard2,
   output logic [$clog2(DEPTH):0]  count
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] C_FULL = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W:0] C_ONE  = (PTR_W+1)'(1);

   logic [4:0]       addr_q [DEPTH];
   logic [31:0]      data_q [DEPTH][LANES];
   logic [LANES-1:0] mask_q [DEPTH];

   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic [PTR_W:0]   count_q, count_d;
   logic             pop;
   logic             push;
   logic             merge_hit;

   assign pop = (count_q != '0) && !hold;

`ifdef VWB_MERGE_EN
   logic [PTR_W-1:0] last_idx;
   assign last_idx  = tail_q - PTR_W'(1);
   // The youngest entry is only off-limits when it is also the head leaving this cycle.
   assign merge_hit = (count_q != '0) && (in_addr == addr_q[last_idx])
                      && !(pop && (count_q == C_ONE));
`else
   assign merge_hit = 1'b0;
`endif

   assign in_ready = (count_q < C_FULL) || merge_hit;
   assign push     = in_valid && in_ready && (|in_mask) && !merge_hit;
   assign count    = count_q;

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
      if (pop) begin
         head_d = head_q + PTR_W'(1);
      end
      if (push) begin
         tail_d = tail_q + PTR_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Payload storage is intentionally not reset; occupancy alone defines validity.
   always_ff @(posedge clk) begin
      if (push) begin
         addr_q[tail_q] <= in_addr;
         mask_q[tail_q] <= in_mask;
         for (int l = 0; l < LANES; l++) begin
            data_q[tail_q][l] <= in_data[l];
         end
      end
`ifdef VWB_MERGE_EN
      else if (in_valid && merge_hit) begin
         mask_q[last_idx] <= mask_q[last_idx] | in_mask;
         for (int l = 0; l < LANES; l++) begin
            if (in_mask[l]) begin
               data_q[last_idx][l] <= in_data[l];
            end
         end
      end
`endif
   end

   always_comb begin
      write_addr = '0;
      we         = '0;
      for (int l = 0; l < LANES; l++) begin
         write_vector[l] = '0;
      end
      if (count_q != '0) begin
         write_addr = addr_q[head_q];
         for (int l = 0; l < LANES; l++) begin
            write_vector[l] = data_q[head_q][l];
         end
      end
      if (pop) begin
         we = mask_q[head_q];
      end
   end

   // The head being popped is skipped: the register file forwards its write.
   always_comb begin
      logic [PTR_W-1:0] idx;
      idx        = '0;
      rd_hazard1 = 1'b0;
      rd_hazard2 = 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
         idx = head_q + PTR_W'(k);
         if (((PTR_W+1)'(k) < count_q) && !((k == 0) && pop)) begin
            if (addr_q[idx] == read1) begin
               rd_hazard1 = 1'b1;
            end
            if (addr_q[idx] == read2) begin
               rd_hazard2 = 1'b1;
            end
         end
      end
   end

endmodule
`default_nettype wire
